// File: rtl/bimodal_predictor.sv
// rtl/bimodal_predictor.sv - bimodal branch predictor with in-order resolution queue
//
// Purpose: a table of 2-bit saturating counters predicts branch direction and target.
// Each accepted prediction is remembered in an in-order queue until the branch resolves;
// a resolution that disagrees with the prediction raises a one-cycle flush with the
// correct next address and clears every outstanding prediction.
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   pred_valid, pred_pc, pred_off      lookup request (accepted when pred_ready is high)
//   pred_ready                         queue not full
//   pred_out_valid, pred_taken,
//   pred_target                        registered prediction, one cycle after accept
//   upd_valid, upd_taken               in-order branch resolution
//   flush, flush_pc                    mispredict pulse and corrected next address
//   err_underflow                      sticky: resolution arrived with nothing queued
//   mispredict_cnt                     saturating mispredict counter
module bimodal_predictor #(
    parameter int ADDR_W   = 5,
    parameter int ENTRIES  = 8,
    parameter int INFLIGHT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pred_valid,
    input  logic [ADDR_W-1:0] pred_pc,
    input  logic [ADDR_W-1:0] pred_off,
    output logic              pred_ready,
    output logic              pred_out_valid,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic              upd_taken,
    output logic              flush,
    output logic [ADDR_W-1:0] flush_pc,
    output logic              err_underflow,
    output logic [15:0]       mispredict_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int PTR_W = $clog2(INFLIGHT);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(INFLIGHT);

    logic [1:0]        r_ctr   [ENTRIES];
    logic [IDX_W-1:0]  r_q_idx [INFLIGHT];
    logic              r_q_tkn [INFLIGHT];
    logic [ADDR_W-1:0] r_q_tt  [INFLIGHT];
    logic [ADDR_W-1:0] r_q_tn  [INFLIGHT];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic [IDX_W-1:0]  w_idx;
    logic              w_lookup_taken;
    logic [ADDR_W-1:0] w_sum_t;
    logic [ADDR_W-1:0] w_sum_n;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_mis;
    logic [IDX_W-1:0]  w_head_idx;
    logic [1:0]        w_head_ctr;
    logic [1:0]        w_ctr_next;

    assign w_idx          = pred_pc[IDX_W-1:0];
    assign w_lookup_taken = r_ctr[w_idx][1];
    assign w_sum_t        = pred_pc + pred_off;
    assign w_sum_n        = pred_pc + ADDR_W'(1);
    assign w_full         = (r_count == FULL_CNT);
    assign w_empty        = (r_count == '0);
    assign pred_ready     = !w_full;
    assign w_push         = pred_valid && !w_full;
    assign w_pop          = upd_valid && !w_empty;
    assign w_mis          = w_pop && (upd_taken != r_q_tkn[r_head]);
    assign w_head_idx     = r_q_idx[r_head];
    assign w_head_ctr     = r_ctr[w_head_idx];

    always_comb begin
        w_ctr_next = w_head_ctr;
        if (upd_taken) begin
            if (w_head_ctr != 2'b11) w_ctr_next = w_head_ctr + 2'b01;
        end else begin
            if (w_head_ctr != 2'b00) w_ctr_next = w_head_ctr - 2'b01;
        end
    end

    // Table reads above see the pre-update counter, so a same-cycle lookup and
    // resolution on one index naturally gets read-before-write behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= 2'b10;
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            pred_out_valid <= 1'b0;
            pred_taken     <= 1'b0;
            pred_target    <= '0;
            flush          <= 1'b0;
            flush_pc       <= '0;
            err_underflow  <= 1'b0;
            mispredict_cnt <= '0;
        end else begin
            pred_out_valid <= w_push;
            if (w_push) begin
                pred_taken  <= w_lookup_taken;
                pred_target <= w_lookup_taken ? w_sum_t : w_sum_n;
            end

            // A push that coincides with a mispredict belongs to the wrong path.
            if (w_push && !w_mis) begin
                r_q_idx[r_tail] <= w_idx;
                r_q_tkn[r_tail] <= w_lookup_taken;
                r_q_tt[r_tail]  <= w_sum_t;
                r_q_tn[r_tail]  <= w_sum_n;
            end

            if (w_pop) r_ctr[w_head_idx] <= w_ctr_next;

            if (w_mis) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_tail <= r_tail + PTR_W'(1);
                if (w_pop)  r_head <= r_head + PTR_W'(1);
                if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
                else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
            end

            flush <= w_mis;
            if (w_mis) flush_pc <= upd_taken ? r_q_tt[r_head] : r_q_tn[r_head];

            if (upd_valid && w_empty) err_underflow <= 1'b1;

            if (w_mis && (mispredict_cnt != 16'hFFFF))
                mispredict_cnt <= mispredict_cnt + 16'd1;
        end
    end

endmodule
